// File: rtl/addsub_seq16.sv
// Multi-precision add/subtract sequencer driving an external 16-bit adder word by word.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_seq16 #(
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    input  logic                  sub,
    output logic [15:0]           fa_a,
    output logic [15:0]           fa_b,
    output logic                  fa_ci,
    input  logic [15:0]           fa_s,
    input  logic                  fa_co,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   result,
    output logic                  carry,
    output logic                  overflow,
    output logic                  zero
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          c_reg;
    logic [IW-1:0] idx;
    logic          last;
    logic          ovf_next;
    logic [W-1:0]  sum_next;
    logic [W-1:0]  res_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (state == RUN) && (idx == LAST);

    assign fa_a  = (state == RUN) ? a_reg[16*idx +: 16] : 16'h0;
    assign fa_b  = (state == RUN) ? b_reg[16*idx +: 16] : 16'h0;
    assign fa_ci = (state == RUN) ? c_reg : 1'b0;

    // b_reg already holds the effective (possibly inverted) operand
    assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (fa_s[15] != a_reg[W-1]);

    always_comb begin
        sum_next = result;
        sum_next[16*idx +: 16] = fa_s;
    end

`ifdef ADDSUB_SAT_EN
    always_comb begin
        res_next = sum_next;
        if (last && ovf_next) begin
            res_next = a_reg[W-1] ? {1'b1, {(W-1){1'b0}}}
                                  : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign res_next = sum_next;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        b_reg <= sub ? ~op_b : op_b;
                        c_reg <= sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= res_next;
                    c_reg  <= fa_co;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        carry    <= fa_co;
                        overflow <= ovf_next;
                        zero     <= (res_next == '0);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_seq16.sv
// Directed bench for addsub_seq16 (WORDS=2) with a behavioural 16-bit adder
// and an arithmetic reference model checked on every result-valid cycle.
module tb_addsub_seq16;
    localparam int WORDS = 2;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic [15:0]  fa_a, fa_b, fa_s;
    logic         fa_ci, fa_co;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry, overflow, zero;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] m_res;
    logic         m_c, m_o, m_z;
    logic         ci_log [0:15];

    addsub_seq16 #(.WORDS(WORDS)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub),
        .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci),
        .fa_s(fa_s), .fa_co(fa_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry),
        .overflow(overflow), .zero(zero)
    );

    assign {fa_co, fa_s} = {1'b0, fa_a} + {1'b0, fa_b} + {16'h0, fa_ci};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on whole operands
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
        longint sa, sb, sr;
        longint ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sr = s ? sa - sb : sa + sb;
        m_o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        m_c = s ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
        m_res = s ? a - b : a + b;
`ifdef ADDSUB_SAT_EN
        if (m_o) m_res = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        m_z = (m_res == 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            chk("res", result, m_res);
            chk("carry", {31'h0, carry}, {31'h0, m_c});
            chk("ovf", {31'h0, overflow}, {31'h0, m_o});
            chk("zero", {31'h0, zero}, {31'h0, m_z});
            chk("rdy_done", {31'h0, in_ready}, 32'h0);
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("idle_wait", 32'h0, 32'h1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        sub = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        sub = 1'b0;
        model(a, b, s);
    endtask

    task automatic finish_op(input logic [W-1:0] r, input logic c,
                             input logic o, input logic z);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            ci_log[n] = fa_ci;
            n++;
            @(posedge clk);
            #1;
        end
        chk("latency", n, WORDS);
        chk("lit_res", result, r);
        chk("lit_cvz", {29'h0, carry, overflow, zero}, {29'h0, c, o, z});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("taken", {30'h0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        #12;
        chk("rst_rdy", {30'h0, in_ready, out_valid}, 32'h2);
        chk("rst_res", result, 32'h0);
        chk("rst_flags", {29'h0, carry, overflow, zero}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        finish_op(32'h0001_0000, 1'b0, 1'b0, 1'b0);
        chk("ci_add", {30'h0, ci_log[0], ci_log[1]}, 32'h1);

        start_op(32'h0000_0005, 32'h0000_0007, 1'b1);
        finish_op(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        chk("ci_sub", {31'h0, ci_log[0]}, 32'h1);

        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
`ifdef ADDSUB_SAT_EN
        finish_op(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
        finish_op(32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif

        start_op(32'h1234_5678, 32'h1234_5678, 1'b1);
        finish_op(32'h0000_0000, 1'b1, 1'b0, 1'b1);

        start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
`ifdef ADDSUB_SAT_EN
        finish_op(32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        finish_op(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);

        // Backpressure: new pair offered while the result waits
        start_op(32'h0001_0002, 32'h0003_0004, 1'b0);
        for (int i = 0; i < 4 && !out_valid; i++) @(negedge clk);
        chk("bp_valid", {31'h0, out_valid}, 32'h1);
        in_valid = 1'b1;
        op_a = 32'hA000_0001;
        op_b = 32'h1000_0002;
        sub = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {30'h0, out_valid, in_ready}, 32'h2);
            chk("bp_res", result, 32'h0004_0006);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_rel", {30'h0, out_valid, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_acc", {31'h0, in_ready}, 32'h0);
        model(32'hA000_0001, 32'h1000_0002, 1'b1);
        finish_op(32'h8FFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Reset during the first RUN cycle
        start_op(32'h0005_0003, 32'h0001_0001, 1'b1);
        chk("pre_rst", {15'h0, fa_ci, fa_a}, 32'h1_0003);
        reset_n = 1'b0;
        #1;
        chk("rst_mid", {14'h0, in_ready, out_valid, fa_a}, 32'h2_0000);
        chk("rst_mid_fa", {15'h0, fa_ci, fa_b}, 32'h0);
        chk("rst_mid_r", {result[30:0], carry} | {31'h0, overflow | zero}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("no_valid", {31'h0, seen}, 32'h0);
        end

        start_op(32'h0000_1111, 32'h0000_2222, 1'b0);
        finish_op(32'h0000_3333, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
